// File: rtl/multi_op_register.sv
// Width-generic accumulator: clear/load/inc/dec/shift plus a multi-cycle shift-by-N engine.
// Optional rotate mode (adds port rot) under `MULTI_OP_REGISTER_ROTATE_EN.
module multi_op_register #(
  parameter int WIDTH = 4,
  parameter int SAT   = 0,
  parameter int SHW   = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cl,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic             sr,
  input  logic             ir,
  input  logic             sl,
  input  logic             il,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
  input  logic             dir,
  input  logic [SHW-1:0]   shamt,
`ifdef MULTI_OP_REGISTER_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [SHW-1:0]   WMAX = SHW'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic             rot_q, rot_d;
  logic             sr_fill, sl_fill, eng_fill, rot_now;
  logic [SHW-1:0]   amt;

  // Returns {bit shifted out, shifted value}.
  function automatic logic [WIDTH:0] shift1(
    input logic [WIDTH-1:0] v,
    input logic             right,
    input logic             fill
  );
    if (right) shift1 = {v[0], fill, v[WIDTH-1:1]};
    else       shift1 = {v[WIDTH-1], v[WIDTH-2:0], fill};
  endfunction

`ifdef MULTI_OP_REGISTER_ROTATE_EN
  assign rot_now = rot;
`else
  assign rot_now = 1'b0;
`endif

  assign sr_fill  = rot_now ? out_q[0] : ir;
  assign sl_fill  = rot_now ? out_q[WIDTH-1] : il;
  assign eng_fill = !rot_q ? fill_q :
                    (dir_q ? out_q[0] : out_q[WIDTH-1]);
  assign amt      = (shamt > WMAX) ? WMAX : shamt;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    rot_d   = rot_q;
    unique case (state_q)
      S_SHIFT: begin
        if (cl) begin
          out_d   = '0;
          carry_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          {carry_d, out_d} = shift1(out_q, dir_q, eng_fill);
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) state_d = S_DONE;
        end
      end
      default: begin
        if (state_q != S_IDLE) state_d = S_IDLE;
        if (cl) begin
          out_d   = '0;
          carry_d = 1'b0;
        end else if (ld) begin
          out_d   = in;
          carry_d = 1'b0;
        end else if (inc) begin
          carry_d = (out_q == ONES);
          if (!(SAT != 0 && out_q == ONES)) out_d = out_q + WIDTH'(1);
        end else if (dec) begin
          carry_d = (out_q == '0);
          if (!(SAT != 0 && out_q == '0)) out_d = out_q - WIDTH'(1);
        end else if (sr) begin
          {carry_d, out_d} = shift1(out_q, 1'b1, sr_fill);
        end else if (sl) begin
          {carry_d, out_d} = shift1(out_q, 1'b0, sl_fill);
        end else if (start && state_q == S_IDLE) begin
          cnt_d   = amt;
          dir_d   = dir;
          fill_d  = dir ? ir : il;
          rot_d   = rot_now;
          state_d = (amt == '0) ? S_DONE : S_SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      rot_q   <= rot_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign zero  = (out_q == '0);
  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_multi_op_register.sv
// Scoreboard bench for multi_op_register: wrap and saturating instances side by side.
// Reference model tracks value, carry, remaining shifts and a pending done flag.
module tb_multi_op_register;

  logic       clk, rst_n;
  logic       cl, ld, inc, dec, sr, ir, sl, il, start, dir, rot;
  logic [3:0] in;
  logic [2:0] shamt;
  logic [3:0] out0, out1;
  logic       carry0, carry1, zero0, zero1;
  logic       busy0, busy1, done0, done1;

  int nchk = 0;
  int nfail = 0;

  multi_op_register #(.WIDTH(4), .SAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .inc(inc), .dec(dec),
    .sr(sr), .ir(ir), .sl(sl), .il(il), .in(in), .start(start),
    .dir(dir), .shamt(shamt),
`ifdef MULTI_OP_REGISTER_ROTATE_EN
    .rot(rot),
`endif
    .out(out0), .carry(carry0), .zero(zero0), .busy(busy0), .done(done0)
  );

  multi_op_register #(.WIDTH(4), .SAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .inc(inc), .dec(dec),
    .sr(sr), .ir(ir), .sl(sl), .il(il), .in(in), .start(start),
    .dir(dir), .shamt(shamt),
`ifdef MULTI_OP_REGISTER_ROTATE_EN
    .rot(rot),
`endif
    .out(out1), .carry(carry1), .zero(zero1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state, index 0 = wrapping, 1 = saturating
  int   mv[2];
  bit   mc[2];
  int   mrem[2];
  bit   mdone[2];
  bit   mdir[2];
  bit   mfill[2];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pack(input int s);
    pack = {4'(mv[s]), mc[s], mv[s] == 0, mrem[s] > 0, mdone[s]};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mv[s] = 0; mc[s] = 0; mrem[s] = 0; mdone[s] = 0;
    end
  endtask

  task automatic shift_model(input int s, input bit right, input bit f);
    if (right) begin
      mc[s] = mv[s] % 2;
      mv[s] = mv[s] / 2 + 8 * f;
    end else begin
      mc[s] = mv[s] / 8;
      mv[s] = (mv[s] * 2) % 16 + f;
    end
  endtask

  task automatic model_step(input int s);
    bit was_done;
    int n;
    was_done = mdone[s];
    mdone[s] = 0;
    if (mrem[s] > 0) begin
      if (cl) begin
        mv[s] = 0; mc[s] = 0; mrem[s] = 0;
      end else begin
        shift_model(s, mdir[s], mfill[s]);
        mrem[s]--;
        if (mrem[s] == 0) mdone[s] = 1;
      end
    end else if (cl) begin
      mv[s] = 0; mc[s] = 0;
    end else if (ld) begin
      mv[s] = int'(in); mc[s] = 0;
    end else if (inc) begin
      mc[s] = (mv[s] == 15);
      if (!(s == 1 && mv[s] == 15)) mv[s] = (mv[s] + 1) % 16;
    end else if (dec) begin
      mc[s] = (mv[s] == 0);
      if (!(s == 1 && mv[s] == 0)) mv[s] = (mv[s] + 15) % 16;
    end else if (sr) begin
      shift_model(s, 1'b1, ir);
    end else if (sl) begin
      shift_model(s, 1'b0, il);
    end else if (start && !was_done) begin
      n = (int'(shamt) > 4) ? 4 : int'(shamt);
      mdir[s] = dir;
      mfill[s] = dir ? ir : il;
      if (n == 0) mdone[s] = 1;
      else mrem[s] = n;
    end
  endtask

  task automatic clear_in();
    cl = 0; ld = 0; inc = 0; dec = 0; sr = 0; sl = 0;
    ir = 0; il = 0; start = 0; dir = 0; rot = 0;
    in = '0; shamt = '0;
  endtask

  // One clock edge: model follows the inputs currently applied.
  task automatic step();
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    q0.push_back(pack(0));
    q1.push_back(pack(1));
    clear_in();
  endtask

  task automatic sample();
    #3;
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) cmp("sb_wrap", {out0, carry0, zero0, busy0, done0}, q0.pop_front());
    if (q1.size() > 0) cmp("sb_sat", {out1, carry1, zero1, busy1, done1}, q1.pop_front());
  end

  int  nb, didx;
  bit  saw;

  initial begin
    clear_in();
    rst_n = 0;
    model_reset();
    #12;
    cmp("reset_state", {out0, carry0, zero0, busy0, done0}, 8'b0000_0_1_0_0);
    rst_n = 1;

    ld = 1; in = 4'hA; step(); sample();
    cmp("ld_A", {out0, carry0, zero0}, {4'hA, 2'b00});

    @(negedge clk); #1;
    rst_n = 0;
    #1;
    cmp("async_rst", {out0, zero0, out1, zero1}, {4'h0, 1'b1, 4'h0, 1'b1});
    model_reset();
    #1 rst_n = 1;

    ld = 1; in = 4'hF; step();
    inc = 1; step(); sample();
    cmp("inc_wrap", {out0, carry0, zero0}, {4'h0, 2'b11});
    cmp("inc_sat", {out1, carry1}, {4'hF, 1'b1});

    ld = 1; in = 4'h0; step();
    dec = 1; step(); sample();
    cmp("dec_wrap", {out0, carry0}, {4'hF, 1'b1});
    cmp("dec_sat", {out1, carry1}, {4'h0, 1'b1});

    ld = 1; in = 4'b1001; step();
    sr = 1; ir = 1; step(); sample();
    cmp("sr_fill", {out0, carry0}, {4'b1100, 1'b1});
    sl = 1; il = 0; step(); sample();
    cmp("sl_fill", {out0, carry0}, {4'b1000, 1'b1});

    ld = 1; in = 4'b0110; step();
    start = 1; dir = 0; shamt = 3; il = 1; step();
    nb = 0; didx = -1;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (busy0) nb++;
      if (done0 && didx < 0) begin
        didx = i;
        cmp("sh3_result", {out0, carry0}, {4'b0111, 1'b1});
      end
      step();
    end
    cmp("sh3_busy_cycles", 8'(nb), 8'd3);
    cmp("sh3_done_index", 8'(didx), 8'd3);

    ld = 1; in = 4'b0110; step();
    start = 1; dir = 0; shamt = 7; il = 1; step();
    repeat (5) step();
    sample();
    cmp("sh_clamp", out0, 8'hF);

    ld = 1; in = 4'h5; step();
    start = 1; dir = 1; shamt = 0; step(); sample();
    cmp("sh0_done", {out0, busy0, done0}, {4'h5, 2'b01});

    cl = 1; ld = 1; inc = 1; in = 4'h9; step(); sample();
    cmp("prio_cl", out0, 8'h0);

    ld = 1; in = 4'h9; step();
    start = 1; dir = 1; shamt = 4; step();
    ld = 1; in = 4'h3; step();
    cl = 1; step(); sample();
    cmp("abort_cl", {out0, busy0}, {4'h0, 1'b0});
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      if (done0) saw = 1;
      step(); sample();
    end
    cmp("abort_nodone", 8'(saw), 8'd0);

    for (int i = 0; i < 400; i++) begin
      cl    = ($urandom % 24) == 0;
      ld    = ($urandom % 6) == 0;
      inc   = ($urandom % 5) == 0;
      dec   = ($urandom % 5) == 0;
      sr    = ($urandom % 6) == 0;
      sl    = ($urandom % 6) == 0;
      start = ($urandom % 3) == 0;
      ir    = $urandom % 2;
      il    = $urandom % 2;
      dir   = $urandom % 2;
      in    = 4'($urandom);
      shamt = 3'($urandom);
      step();
    end

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/multi_op_register.md
Name: multi_op_register

Overview:
- Parametrised successor to the 4-bit multi-function register in the datapath.
- Width-generic register with:
  - clear, load, increment and decrement, with optional saturation;
  - single-bit shifts with serial fill;
  - carry and zero flags;
  - a multi-cycle shift-by-N engine with a busy/done handshake.
- Sits beside the ALU as the accumulator/working register of the CPU datapath.

Parameters:
- WIDTH, 4: register width in bits, must be at least 2.
- SAT, 0: 0 makes inc/dec wrap around; 1 makes them saturate at all-ones/zero.
- SHW, $clog2(WIDTH+1): width of shamt.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cl  in  1  clear.
- ld  in  1  load from in.
- inc  in  1  increment.
- dec  in  1  decrement.
- sr  in  1  shift right one bit, ir fills the MSB.
- ir  in  1  serial fill bit for right shifts.
- sl  in  1  shift left one bit, il fills the LSB.
- il  in  1  serial fill bit for left shifts.
- in  in  WIDTH  parallel load data.
- start  in  1  begin a multi-cycle shift.
- dir  in  1  multi-cycle shift direction: 1 = right, 0 = left.
- shamt  in  SHW  multi-cycle shift amount.
- out  out  WIDTH  register value.
- carry  out  1  carry/borrow or last bit shifted out.
- zero  out  1  high when out == 0 (combinational from out).
- busy  out  1  multi-cycle shift in progress.
- done  out  1  one-cycle pulse when a multi-cycle shift completes.

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset, rst_n. While rst_n = 0: out = 0, carry = 0, busy = 0, done = 0, FSM = IDLE, and zero reads 1. Reset mid-shift aborts the shift and no done pulse is issued.
- All other updates happen on the rising edge of clk.
- Priority in IDLE, highest first: cl > ld > inc > dec > sr > sl > start. At most one action per cycle; lower-priority requests in the same cycle are dropped, not queued.
- cl: out = 0, carry = 0.
- ld: out = in, carry = 0.
- inc:
  - SAT = 0: out = out + 1 modulo 2^WIDTH; carry = 1 only when out was all-ones.
  - SAT = 1: at all-ones, out holds and carry = 1; otherwise out = out + 1 and carry = 0.
- dec:
  - SAT = 0: out = out - 1 modulo 2^WIDTH; carry (borrow) = 1 only when out was 0.
  - SAT = 1: at 0, out holds and carry = 1; otherwise out = out - 1 and carry = 0.
- sr: out = {ir, out[WIDTH-1:1]}, carry = out[0].
- sl: out = {out[WIDTH-2:0], il}, carry = out[WIDTH-1].
- No request asserted: out and carry hold.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start accepted:
  - Latch cnt = min(shamt, WIDTH).
  - Latch direction = dir.
  - Latch fill = ir if dir = 1, il if dir = 0.
  - cnt = 0: go to DONE; out and carry unchanged.
  - cnt > 0: go to SHIFT.
- SHIFT:
  - busy = 1.
  - Each cycle: shift one bit in the latched direction using the latched fill bit; carry = bit shifted out; cnt decrements.
  - When cnt reaches 0, go to DONE.
  - Latency: a shift by k keeps busy high for k cycles.
- DONE: done = 1 for exactly one cycle, busy = 0, then return to IDLE. done appears k+1 cycles after the start edge.
- Inputs while busy:
  - cl aborts: out = 0, carry = 0, FSM returns to IDLE, and no done pulse follows.
  - ld, inc, dec, sr, sl and start are ignored.
- Inputs in DONE: single-cycle ops are accepted as in IDLE; start is ignored.
- Shift amounts: shamt > WIDTH is clamped to WIDTH. A full-width shift leaves out = fill replicated across all bits.

Optional Feature:
- Macro: MULTI_OP_REGISTER_ROTATE_EN.
- Defined:
  - Adds input port rot (1 bit).
  - rot = 1 on an sr or sl cycle: rotate instead of fill. sr gives out = {out[0], out[WIDTH-1:1]}; sl gives out = {out[WIDTH-2:0], out[WIDTH-1]}; carry = the bit that wrapped.
  - rot sampled with start = 1: the whole multi-cycle operation rotates and ignores the fill bit.
- Not defined: no rot port; behaviour exactly as above.

Test Plan (WIDTH=4, SAT=0 unless noted):
- Reset then ld with in = 4'hA -> out = 4'hA, carry = 0, zero = 0. Assert rst_n low mid-cycle -> out = 0 and zero = 1 immediately, before the next clk edge.
- ld 4'hF, then inc -> out = 0, carry = 1, zero = 1. With SAT = 1, same stimulus -> out = 4'hF, carry = 1. ld 0, then dec with SAT = 0 -> out = 4'hF, carry = 1.
- ld 4'b1001, then sr with ir = 1 -> out = 4'b1100, carry = 1. Then sl with il = 0 -> out = 4'b1000, carry = 1.
- ld 4'b0110; start with dir = 0, shamt = 3, il = 1 -> busy high for 3 cycles, out = 4'b0111, carry = 1, done pulses 4 cycles after start. shamt = 7 -> clamped to 4, out = 4'b1111. shamt = 0 -> done next cycle, out unchanged.
- Same cycle cl = ld = inc = 1 -> out = 0. During a shift with shamt = 4, pulse ld, then cl on cycle 2 -> ld ignored; cl gives out = 0, busy = 0, and no done pulse.
- With MULTI_OP_REGISTER_ROTATE_EN: ld 4'b1001, sr with rot = 1 -> out = 4'b1100, carry = 1. Start with rot = 1, dir = 1, shamt = 4 -> out returns to 4'b1100.
